alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Registered, parameterised successor to the combinational 8-bit ALU. It accepts operands and an opcode over a valid/ready handshake and executes variable-amount shifts iteratively. It returns the result with a full flag set (zero, negative, carry, overflow) over a second valid/ready handshake. It sits between the operand/opcode source (switch/UART front end) and the result consumer. It owns all timing, so the front end no longer depends on combinational ALU paths.

Parameters:
BUS_SIZE, 8, operand/result width in bits (>= 4, power of two).
OPCODE_SIZE, 6, opcode width.
SHAMT_SIZE, $clog2(BUS_SIZE), shift-amount width, taken from num2[SHAMT_SIZE-1:0].
ADD/SUB/AND/OR/XOR/NOR, 6'b100000/100010/100100/100101/100110/100111, arithmetic/logic opcodes.
SLL/SRL/SRA, 6'b000000/000010/000011, shift opcodes; shift amount comes from num2.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
num1  input  BUS_SIZE  operand A.
num2  input  BUS_SIZE  operand B; shift amount for SLL/SRL/SRA.
opcode  input  OPCODE_SIZE  operation select.
in_valid  input  1  operands/opcode valid.
in_ready  output  1  block can accept an operation.
out  output  BUS_SIZE  registered result.
carry  output  1  ADD carry-out / SUB borrow.
overflow  output  1  signed overflow (ADD/SUB).
zero  output  1  out == 0.
negative  output  1  out[BUS_SIZE-1].
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer takes result.

Behaviour:
- Reset: async assert when rst_n=0.
  - state=IDLE; out, carry, overflow, zero, negative, out_valid all 0.
  - Shift counter and operand latches cleared.
  - in_ready=1 (IDLE), but inputs are ignored while rst_n=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid=1, latch num1, num2, opcode; this is the accept edge.
    - Non-shift op, or shift with amount k=0: compute and go to DONE.
    - Shift with k>0: load counter=k, working reg=num1, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0.
    - Each cycle: shift working reg 1 bit (SLL: zero fill LSB; SRL: zero fill MSB; SRA: replicate MSB); decrement counter.
    - When counter goes 1->0, result=working reg, go to DONE.
  - DONE: out_valid=1, in_ready=0; out and flags held stable.
    - On out_ready=1: go to IDLE; out_valid drops next cycle.
    - out and flags keep their last values until the next result.
- Latency, measured from the accept edge:
  - Non-shift ops and k=0: out_valid high 1 cycle later.
  - Shift by k>0: out_valid high k+1 cycles later.
  - Minimum issue interval is 2 cycles (in_ready is low in DONE). No same-cycle accept/retire.
- Arithmetic, all BUS_SIZE-bit with wrap-around:
  - ADD: carry = bit BUS_SIZE of the zero-extended sum.
  - SUB: carry=1 iff num1 < num2 (unsigned borrow).
  - overflow (ADD/SUB only): operands' signs match (ADD) or differ (SUB), and the result sign differs from num1's.
  - All other ops: carry=0, overflow=0.
  - zero and negative are computed from the final result for every op.
- Unknown opcode executes ADD with ADD flags. This keeps the legacy default.
- in_valid while in SHIFT/DONE is ignored; the source must hold until in_ready=1.
- out_ready while out_valid=0 is ignored.
- num1/num2/opcode changes after acceptance do not affect the in-flight op.

Optional Feature:
ALU_BARREL_SHIFT_EN:
- Defined: shifts use a combinational barrel shifter; every op has 1-cycle latency; the SHIFT state and counter are not built.
- Undefined: iterative 1-bit/cycle shifting as above, for minimum area.
- Results and flags are identical in both builds; only latency differs.

Test Plan:
- Reset, then ADD num1=8'hFF num2=8'h01 -> 1 cycle after accept: out=8'h00, carry=1, zero=1, overflow=0, negative=0, out_valid=1.
- ADD 8'h7F+8'h01 -> out=8'h80, overflow=1, negative=1, carry=0. SUB 8'h05-8'h07 -> out=8'hFE, carry=1, overflow=0, negative=1.
- SRA num1=8'h90 num2=8'h03 -> out=8'hF2, out_valid 4 cycles after accept (1 cycle with ALU_BARREL_SHIFT_EN). SRL same operands -> 8'h12. SLL num2=8'h00 -> out=8'h90, 1-cycle latency.
- Backpressure: XOR 8'hAA^8'h0F with out_ready=0 for 5 cycles -> out=8'hA5 held, out_valid=1, in_ready=0 throughout. A second in_valid pulse during the stall is ignored. out_ready=1 -> IDLE next cycle.
- Unknown opcode 6'b111111 with num1=8'h10 num2=8'h20 -> out=8'h30, carry=0.
- Assert rst_n=0 mid-SHIFT (SLL 8'h01 by 7, 3 cycles in) -> immediately out=0, out_valid=0, all flags 0. After release in_ready=1, and the next AND 8'hF0&8'h3C returns 8'h30.

Source files
------------

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/opcode request and result/flag response handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int BUS_SIZE    = 8,
    parameter int OPCODE_SIZE = 6
);
    // Request channel: operand/opcode source to ALU
    logic [BUS_SIZE-1:0]    num1;
    logic [BUS_SIZE-1:0]    num2;
    logic [OPCODE_SIZE-1:0] opcode;
    logic                   in_valid;
    logic                   in_ready;

    // Response channel: ALU to result consumer
    logic [BUS_SIZE-1:0]    out;
    logic                   carry;
    logic                   overflow;
    logic                   zero;
    logic                   negative;
    logic                   out_valid;
    logic                   out_ready;

    // Front end side: issues operations and consumes results
    modport master (
        output num1, num2, opcode, in_valid, out_ready,
        input  in_ready, out, carry, overflow, zero, negative, out_valid
    );

    // ALU side
    modport slave (
        input  num1, num2, opcode, in_valid, out_ready,
        output in_ready, out, carry, overflow, zero, negative, out_valid
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered handshake ALU with iterative shifts and zero/negative/carry/overflow flags
// Optional feature macro: ALU_BARREL_SHIFT_EN (single-cycle barrel shifter, no SHIFT state or counter).
module alu_pipe #(
    parameter int BUS_SIZE    = 8,
    parameter int OPCODE_SIZE = 6,
    parameter int SHAMT_SIZE  = $clog2(BUS_SIZE),
    parameter logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(6'b100000),
    parameter logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(6'b100010),
    parameter logic [OPCODE_SIZE-1:0] OP_AND = OPCODE_SIZE'(6'b100100),
    parameter logic [OPCODE_SIZE-1:0] OP_OR  = OPCODE_SIZE'(6'b100101),
    parameter logic [OPCODE_SIZE-1:0] OP_XOR = OPCODE_SIZE'(6'b100110),
    parameter logic [OPCODE_SIZE-1:0] OP_NOR = OPCODE_SIZE'(6'b100111),
    parameter logic [OPCODE_SIZE-1:0] OP_SLL = OPCODE_SIZE'(6'b000000),
    parameter logic [OPCODE_SIZE-1:0] OP_SRL = OPCODE_SIZE'(6'b000010),
    parameter logic [OPCODE_SIZE-1:0] OP_SRA = OPCODE_SIZE'(6'b000011)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Architectural state
    logic [1:0]          state_q,    state_d;
    logic [BUS_SIZE-1:0] out_q,      out_d;
    logic                carry_q,    carry_d;
    logic                overflow_q, overflow_d;
    logic                zero_q,     zero_d;
    logic                negative_q, negative_d;

`ifndef ALU_BARREL_SHIFT_EN
    // Iterative shifter: latched opcode, working register and remaining count
    logic [OPCODE_SIZE-1:0] op_q,   op_d;
    logic [BUS_SIZE-1:0]    work_q, work_d;
    logic [SHAMT_SIZE-1:0]  cnt_q,  cnt_d;
    logic [BUS_SIZE-1:0]    work_shifted;
`endif

    // Combinational evaluation of the operation presented on the request channel
    logic [BUS_SIZE:0]     sum_ext;
    logic [BUS_SIZE-1:0]   diff;
    logic [BUS_SIZE-1:0]   calc_res;
    logic                  calc_carry;
    logic                  calc_ovf;
    logic [SHAMT_SIZE-1:0] shamt;
    logic                  is_shift;

    assign shamt    = bus.num2[SHAMT_SIZE-1:0];
    assign is_shift = (bus.opcode == OP_SLL) || (bus.opcode == OP_SRL) ||
                      (bus.opcode == OP_SRA);

    // Result and carry/overflow for the incoming operands; unknown opcodes fall back to ADD
    always_comb begin
        sum_ext    = {1'b0, bus.num1} + {1'b0, bus.num2};
        diff       = bus.num1 - bus.num2;
        calc_res   = sum_ext[BUS_SIZE-1:0];
        calc_carry = sum_ext[BUS_SIZE];
        calc_ovf   = (bus.num1[BUS_SIZE-1] == bus.num2[BUS_SIZE-1]) &&
                     (sum_ext[BUS_SIZE-1] != bus.num1[BUS_SIZE-1]);
        case (bus.opcode)
            OP_SUB: begin
                calc_res   = diff;
                calc_carry = (bus.num1 < bus.num2);
                calc_ovf   = (bus.num1[BUS_SIZE-1] != bus.num2[BUS_SIZE-1]) &&
                             (diff[BUS_SIZE-1] != bus.num1[BUS_SIZE-1]);
            end
            OP_AND: begin
                calc_res   = bus.num1 & bus.num2;
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
            OP_OR: begin
                calc_res   = bus.num1 | bus.num2;
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
            OP_XOR: begin
                calc_res   = bus.num1 ^ bus.num2;
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
            OP_NOR: begin
                calc_res   = ~(bus.num1 | bus.num2);
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL: begin
                calc_res   = bus.num1 << shamt;
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
            OP_SRL: begin
                calc_res   = bus.num1 >> shamt;
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
            OP_SRA: begin
                calc_res   = $unsigned($signed(bus.num1) >>> shamt);
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
`else
            // Only reached with a zero shift amount; non-zero amounts go through SHIFT
            OP_SLL, OP_SRL, OP_SRA: begin
                calc_res   = bus.num1;
                calc_carry = 1'b0;
                calc_ovf   = 1'b0;
            end
`endif
            default: ;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    // One-bit step of the iterative shifter; anything other than SLL/SRL is SRA
    always_comb begin
        case (op_q)
            OP_SLL:  work_shifted = {work_q[BUS_SIZE-2:0], 1'b0};
            OP_SRL:  work_shifted = {1'b0, work_q[BUS_SIZE-1:1]};
            default: work_shifted = {work_q[BUS_SIZE-1], work_q[BUS_SIZE-1:1]};
        endcase
    end
`endif

    // FSM next state: accept in IDLE, step shifts in SHIFT, hold result in DONE
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
`ifndef ALU_BARREL_SHIFT_EN
        op_d       = op_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        op_d    = bus.opcode;
                        work_d  = bus.num1;
                        cnt_d   = shamt;
                        state_d = ST_SHIFT;
                    end else
`endif
                    begin
                        out_d      = calc_res;
                        carry_d    = calc_carry;
                        overflow_d = calc_ovf;
                        zero_d     = (calc_res == '0);
                        negative_d = calc_res[BUS_SIZE-1];
                        state_d    = ST_DONE;
                    end
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                work_d = work_shifted;
                cnt_d  = cnt_q - SHAMT_SIZE'(1);
                if (cnt_q == SHAMT_SIZE'(1)) begin
                    out_d      = work_shifted;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    zero_d     = (work_shifted == '0);
                    negative_d = work_shifted[BUS_SIZE-1];
                    state_d    = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            op_q       <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
`ifndef ALU_BARREL_SHIFT_EN
            op_q       <= op_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out       = out_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and random self-checking bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_pipe_if #(.BUS_SIZE(8), .OPCODE_SIZE(6)) bus ();

    alu_pipe #(.BUS_SIZE(8), .OPCODE_SIZE(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry, result} from signed/unsigned integer arithmetic
    function automatic logic [9:0] ref_alu(input int a, input int b, input logic [5:0] op);
        int sa, sb, k, r, s;
        logic cy, ov;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        k  = b % 8;
        cy = 1'b0;
        ov = 1'b0;
        case (op)
            6'b100010: begin r = a - b; cy = (a < b); s = sa - sb; ov = (s > 127) || (s < -128); end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b000000: r = a << k;
            6'b000010: r = a >> k;
            6'b000011: r = sa >>> k;
            default:   begin r = a + b; cy = (r > 255); s = sa + sb; ov = (s > 127) || (s < -128); end
        endcase
        return {ov, cy, r[7:0]};
    endfunction

    function automatic int ref_latency(input int b, input logic [5:0] op);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((op == 6'b000000 || op == 6'b000010 || op == 6'b000011) && (b % 8) != 0)
            return (b % 8) + 1;
        return 1;
`endif
    endfunction

    // Issue one op, check latency/result/flags, stall the consumer, then retire it
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op, input int stall, input bit poke);
        logic [9:0] exp;
        logic [7:0] r;
        int lat;
        exp = ref_alu(int'(a), int'(b), op);
        r   = exp[7:0];
        lat = 0;
        while (!bus.in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.num1 = a; bus.num2 = b; bus.opcode = op; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.num1 = 8'($urandom); bus.num2 = 8'($urandom); bus.opcode = 6'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check({tag, ".latency"},  32'(lat), 32'(ref_latency(int'(b), op)));
        check({tag, ".out"},      32'(bus.out), 32'(r));
        check({tag, ".carry"},    32'(bus.carry), 32'(exp[8]));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(exp[9]));
        check({tag, ".zero"},     32'(bus.zero), 32'(r == 8'h00));
        check({tag, ".negative"}, 32'(bus.negative), 32'(r[7]));
        check({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            if (poke && s == 1) begin
                bus.num1 = 8'h01; bus.num2 = 8'h01; bus.opcode = 6'b100000; bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check({tag, ".stall_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".stall_out"},   32'(bus.out), 32'(r));
            check({tag, ".stall_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".retire_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".retire_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, ".retire_hold"},  32'(bus.out), 32'(r));
        if (poke) begin
            @(posedge clk); #1;
            check({tag, ".poke_ignored"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] op;
        checks = 0;
        errors = 0;
        ops[0] = 6'b100000; ops[1] = 6'b100010; ops[2] = 6'b100100; ops[3] = 6'b100101;
        ops[4] = 6'b100110; ops[5] = 6'b100111; ops[6] = 6'b000000; ops[7] = 6'b000010;
        ops[8] = 6'b000011;

        rst_n = 1'b0;
        bus.num1 = 8'h00; bus.num2 = 8'h00; bus.opcode = 6'h00;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out",       32'(bus.out), 32'h0);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.flags",     32'({bus.carry, bus.overflow, bus.zero, bus.negative}), 32'h0);
        check("reset.in_ready",  32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_ff_01",  8'hFF, 8'h01, 6'b100000, 0, 1'b0);
        run_op("add_7f_01",  8'h7F, 8'h01, 6'b100000, 0, 1'b0);
        run_op("sub_05_07",  8'h05, 8'h07, 6'b100010, 0, 1'b0);
        run_op("sra_90_3",   8'h90, 8'h03, 6'b000011, 0, 1'b0);
        run_op("srl_90_3",   8'h90, 8'h03, 6'b000010, 0, 1'b0);
        run_op("sll_90_0",   8'h90, 8'h00, 6'b000000, 0, 1'b0);
        run_op("xor_stall",  8'hAA, 8'h0F, 6'b100110, 5, 1'b1);
        run_op("unknown_op", 8'h10, 8'h20, 6'b111111, 0, 1'b0);

        // Reset in the middle of SLL 0x01 by 7
        bus.num1 = 8'h01; bus.num2 = 8'h07; bus.opcode = 6'b000000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.out",       32'(bus.out), 32'h0);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.flags",     32'({bus.carry, bus.overflow, bus.zero, bus.negative}), 32'h0);
        bus.num1 = 8'h33; bus.num2 = 8'h44; bus.opcode = 6'b100000; bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst.ignored", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        run_op("and_after_rst", 8'hF0, 8'h3C, 6'b100100, 0, 1'b0);

        // Random ops with random consumer stalls
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), op,
                   int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
